// File: rtl/tcu_ir_sequencer_if.sv
// Bus between the 6502 decode ROM and the IR/TCU sequencer.
// The slave side is the sequencer; the master side is the decode ROM / bus model.
interface tcu_ir_sequencer_if;
   logic       i_rdy;
   logic       i_rw;
   logic [7:0] i_data;
   logic [2:0] i_tcu_next;
   logic [7:0] o_ir;
   logic [2:0] o_tcu;
   logic       o_sync;
   logic       o_reset_seq;
   logic       o_illegal_tcu;
   logic [3:0] o_cycle_count;

   modport slave (
      input  i_rdy, i_rw, i_data, i_tcu_next,
      output o_ir, o_tcu, o_sync, o_reset_seq, o_illegal_tcu, o_cycle_count
   );

   modport master (
      output i_rdy, i_rw, i_data, i_tcu_next,
      input  o_ir, o_tcu, o_sync, o_reset_seq, o_illegal_tcu, o_cycle_count
   );
endinterface

// File: rtl/tcu_ir_sequencer.sv
// Instruction register and T-state register feeding the 6502 decode ROM.
// Latches the opcode at the end of T1, honours RDY on reads and runs the post-reset sequence.
//
// state (o_tcu) | meaning
// 0..6          | T0..T6 of the current instruction, 1 = opcode fetch (SYNC)
// 7             | never held; an accepted 7 forces T0 and sets the sticky illegal flag
module tcu_ir_sequencer #(
   parameter logic [7:0] RESET_IR  = 8'h00,
   parameter logic [2:0] RESET_TCU = 3'd2
) (
   input  logic                i_clk,
   input  logic                i_reset,
   tcu_ir_sequencer_if.slave   bus
);

   logic [7:0] ir_q,        ir_d;
   logic [2:0] tcu_q,       tcu_d;
   logic       reset_seq_q, reset_seq_d;
   logic       illegal_q,   illegal_d;
   logic [3:0] count_q,     count_d;
   logic       stall;

   // RDY only stretches read cycles; writes always complete.
   assign stall = ~bus.i_rdy & bus.i_rw;

   always_comb begin
      ir_d        = ir_q;
      tcu_d       = tcu_q;
      reset_seq_d = reset_seq_q;
      illegal_d   = illegal_q;
      count_d     = count_q;
      if (!stall) begin
         if (bus.i_tcu_next == 3'd7) begin
            tcu_d     = 3'd0;
            illegal_d = 1'b1;
         end else begin
            tcu_d = bus.i_tcu_next;
         end
         if (tcu_q == 3'd1) begin
            ir_d        = bus.i_data;
            count_d     = 4'd0;
            reset_seq_d = 1'b0;
         end else if (count_q != 4'hF) begin
            count_d = count_q + 4'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ir_q        <= RESET_IR;
         tcu_q       <= RESET_TCU;
         reset_seq_q <= 1'b1;
         illegal_q   <= 1'b0;
         count_q     <= 4'd0;
      end else begin
         ir_q        <= ir_d;
         tcu_q       <= tcu_d;
         reset_seq_q <= reset_seq_d;
         illegal_q   <= illegal_d;
         count_q     <= count_d;
      end
   end

   assign bus.o_ir          = ir_q;
   assign bus.o_tcu         = tcu_q;
   assign bus.o_sync        = (tcu_q == 3'd1);
   assign bus.o_reset_seq   = reset_seq_q;
   assign bus.o_illegal_tcu = illegal_q;
   assign bus.o_cycle_count = count_q;

endmodule

// File: tb/tb_tcu_ir_sequencer.sv
// Self-checking bench for tcu_ir_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-level reference model.
module tb_tcu_ir_sequencer;

   logic i_clk = 1'b0;
   logic i_reset = 1'b0;
   tcu_ir_sequencer_if bus();

   tcu_ir_sequencer dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   int tests_run = 0;
   int tests_failed = 0;

   // reference model state
   int m_ir, m_tcu, m_cnt;
   bit m_rs, m_ill;

   // Drive one cycle's inputs, advance the model by the rules, then take the edge.
   task automatic step(input bit rst, input bit rdy, input bit rw,
                       input logic [7:0] data, input logic [2:0] tn);
      int was_tcu;
      i_reset        = rst;
      bus.i_rdy      = rdy;
      bus.i_rw       = rw;
      bus.i_data     = data;
      bus.i_tcu_next = tn;
      if (rst) begin
         m_ir = 0; m_tcu = 2; m_rs = 1; m_ill = 0; m_cnt = 0;
      end else if (!(rw && !rdy)) begin
         was_tcu = m_tcu;
         if (int'(tn) == 7) begin
            m_tcu = 0; m_ill = 1;
         end else begin
            m_tcu = int'(tn);
         end
         if (was_tcu == 1) begin
            m_ir = int'(data); m_cnt = 0; m_rs = 0;
         end else begin
            m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
         end
      end
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      step(1, 1, 1, 8'h55, 3'd5);
      tests_run++;
      if (bus.o_ir !== 8'h00) begin
         tests_failed++; $display("FAIL reset_ir got %h want 00", bus.o_ir);
      end
      tests_run++;
      if (bus.o_tcu !== 3'd2) begin
         tests_failed++; $display("FAIL reset_tcu got %0d want 2", bus.o_tcu);
      end
      tests_run++;
      if (bus.o_reset_seq !== 1'b1 || bus.o_sync !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_seq_sync got rs=%b sync=%b want rs=1 sync=0", bus.o_reset_seq, bus.o_sync);
      end
      tests_run++;
      if (bus.o_cycle_count !== 4'd0 || bus.o_illegal_tcu !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_cnt_ill got cnt=%0d ill=%b want 0/0", bus.o_cycle_count, bus.o_illegal_tcu);
      end
   endtask

   task automatic test_fetch();
      step(0, 1, 1, 8'h00, 3'd1);
      bus.i_data = 8'hA9;
      bus.i_tcu_next = 3'd2;
      #1;
      tests_run++;
      if (bus.o_sync !== 1'b1 || bus.o_ir !== 8'h00) begin
         tests_failed++;
         $display("FAIL fetch_during_t1 got sync=%b ir=%h want sync=1 ir=00", bus.o_sync, bus.o_ir);
      end
      step(0, 1, 1, 8'hA9, 3'd2);
      tests_run++;
      if (bus.o_ir !== 8'hA9 || bus.o_tcu !== 3'd2) begin
         tests_failed++;
         $display("FAIL fetch_latch got ir=%h tcu=%0d want ir=a9 tcu=2", bus.o_ir, bus.o_tcu);
      end
      tests_run++;
      if (bus.o_reset_seq !== 1'b0 || bus.o_cycle_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL fetch_flags got rs=%b cnt=%0d want rs=0 cnt=0", bus.o_reset_seq, bus.o_cycle_count);
      end
   endtask

   task automatic test_read_stall();
      step(0, 1, 1, 8'h00, 3'd1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 8'hEA, 3'd2);
         tests_run++;
         if (bus.o_tcu !== 3'd1 || bus.o_sync !== 1'b1 || bus.o_ir !== 8'hA9) begin
            tests_failed++;
            $display("FAIL read_stall_%0d got tcu=%0d sync=%b ir=%h want tcu=1 sync=1 ir=a9",
                     i, bus.o_tcu, bus.o_sync, bus.o_ir);
         end
      end
      tests_run++;
      if (int'(bus.o_cycle_count) !== m_cnt || m_cnt != 1) begin
         tests_failed++;
         $display("FAIL read_stall_count got %0d want 1", bus.o_cycle_count);
      end
      step(0, 1, 1, 8'hEA, 3'd2);
      tests_run++;
      if (bus.o_ir !== 8'hEA || bus.o_tcu !== 3'd2) begin
         tests_failed++;
         $display("FAIL read_stall_release got ir=%h tcu=%0d want ir=ea tcu=2", bus.o_ir, bus.o_tcu);
      end
   endtask

   task automatic test_write_no_stall();
      step(0, 1, 1, 8'h11, 3'd3);
      step(0, 0, 0, 8'h22, 3'd4);
      tests_run++;
      if (bus.o_tcu !== 3'd4 || int'(bus.o_cycle_count) !== m_cnt) begin
         tests_failed++;
         $display("FAIL write_no_stall got tcu=%0d cnt=%0d want tcu=4 cnt=%0d",
                  bus.o_tcu, bus.o_cycle_count, m_cnt);
      end
   endtask

   task automatic test_illegal();
      step(0, 1, 1, 8'h33, 3'd7);
      tests_run++;
      if (bus.o_tcu !== 3'd0 || bus.o_illegal_tcu !== 1'b1) begin
         tests_failed++;
         $display("FAIL illegal_set got tcu=%0d ill=%b want tcu=0 ill=1", bus.o_tcu, bus.o_illegal_tcu);
      end
      for (int i = 0; i < 6; i++) step(0, 1'($urandom), 1'($urandom), 8'($urandom), 3'($urandom_range(0, 6)));
      tests_run++;
      if (bus.o_illegal_tcu !== 1'b1 || bus.o_tcu === 3'd7) begin
         tests_failed++;
         $display("FAIL illegal_sticky got ill=%b tcu=%0d want ill=1 tcu!=7", bus.o_illegal_tcu, bus.o_tcu);
      end
      step(1, 1, 1, 8'h00, 3'd0);
      tests_run++;
      if (bus.o_illegal_tcu !== 1'b0) begin
         tests_failed++;
         $display("FAIL illegal_clear got %b want 0", bus.o_illegal_tcu);
      end
   endtask

   task automatic test_saturation_reset();
      step(1, 1, 1, 8'h00, 3'd0);
      for (int i = 0; i < 14; i++) step(0, 1, 1, 8'h44, 3'd2);
      tests_run++;
      if (bus.o_cycle_count !== 4'd14) begin
         tests_failed++;
         $display("FAIL count_14 got %0d want 14", bus.o_cycle_count);
      end
      for (int i = 0; i < 6; i++) step(0, 1, 1, 8'h44, 3'd2);
      tests_run++;
      if (bus.o_cycle_count !== 4'd15 || m_cnt != 15) begin
         tests_failed++;
         $display("FAIL count_saturate got %0d want 15", bus.o_cycle_count);
      end
      step(0, 1, 1, 8'h00, 3'd1);
      step(0, 1, 1, 8'h77, 3'd3);
      step(1, 0, 1, 8'h99, 3'd5);
      tests_run++;
      if (bus.o_ir !== 8'h00 || bus.o_tcu !== 3'd2 || bus.o_reset_seq !== 1'b1 ||
          bus.o_cycle_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_over_stall got ir=%h tcu=%0d rs=%b cnt=%0d want 00/2/1/0",
                  bus.o_ir, bus.o_tcu, bus.o_reset_seq, bus.o_cycle_count);
      end
   endtask

   task automatic test_t1_chain();
      logic [7:0] op;
      step(0, 1, 1, 8'h00, 3'd1);
      for (int i = 0; i < 4; i++) begin
         op = 8'($urandom);
         step(0, 1, 1, op, 3'd1);
         tests_run++;
         if (bus.o_ir !== op || bus.o_tcu !== 3'd1 || bus.o_cycle_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL t1_chain_%0d got ir=%h tcu=%0d cnt=%0d want ir=%h tcu=1 cnt=0",
                     i, bus.o_ir, bus.o_tcu, bus.o_cycle_count, op);
         end
      end
   endtask

   task automatic test_random();
      int errs;
      logic [2:0] tn;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         tn = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
         step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
              8'($urandom), tn);
         tests_run++;
         if (int'(bus.o_ir) !== m_ir || int'(bus.o_tcu) !== m_tcu ||
             bus.o_reset_seq !== m_rs || bus.o_illegal_tcu !== m_ill ||
             int'(bus.o_cycle_count) !== m_cnt || bus.o_sync !== (m_tcu == 1)) begin
            tests_failed++;
            if (errs < 10)
               $display("FAIL random_%0d got ir=%h tcu=%0d rs=%b ill=%b cnt=%0d sync=%b want ir=%h tcu=%0d rs=%b ill=%b cnt=%0d",
                        i, bus.o_ir, bus.o_tcu, bus.o_reset_seq, bus.o_illegal_tcu,
                        bus.o_cycle_count, bus.o_sync, m_ir[7:0], m_tcu, m_rs, m_ill, m_cnt);
            errs++;
         end
      end
   endtask

   initial begin
      bus.i_rdy = 1'b1;
      bus.i_rw = 1'b1;
      bus.i_data = 8'h00;
      bus.i_tcu_next = 3'd0;
      test_reset();
      test_fetch();
      test_read_stall();
      test_write_no_stall();
      test_illegal();
      test_saturation_reset();
      test_t1_chain();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
